// File: rtl/sdadc_pkg.sv
// rtl/sdadc_pkg.sv - shared constants and helpers for the sigma-delta decimator
//
// Purpose : default parameter values, output width helper and signed
//           mid-scale offset used by sdadc_decim, sdadc_sync and sdadc_decim_if.
// Ports   : none (package).
package sdadc_pkg;

  localparam int SDADC_DECIM_LOG2_DEF  = 8;
  localparam int SDADC_SYNC_STAGES_DEF = 2;

  // A full window of ones yields 2^decim_log2, which needs one extra bit.
  function automatic int sdadc_sample_w(input int decim_log2);
    return decim_log2 + 1;
  endfunction

  // Mid-scale offset subtracted in the signed build (half of the window length).
  function automatic int sdadc_mid_offset(input int decim_log2);
    return 1 << (decim_log2 - 1);
  endfunction

  localparam int SDADC_MID_OFFSET = 1 << (SDADC_DECIM_LOG2_DEF - 1);

endpackage

// File: rtl/sdadc_decim_if.sv
// rtl/sdadc_decim_if.sv - decimated sample valid/ready interface
//
// Purpose : carries the decimated sample from sdadc_decim to the DSP chain.
// Signals : o_sample (SAMPLE_W) decimated sample, o_valid sample valid,
//           i_ready downstream accepts sample. Names are from the decimator's view.
// Modports: master (decimator side), slave (consumer side).
interface sdadc_decim_if
  import sdadc_pkg::*;
#(
  parameter int DECIM_LOG2 = SDADC_DECIM_LOG2_DEF
) ();

  localparam int SAMPLE_W = sdadc_sample_w(DECIM_LOG2);

  logic [SAMPLE_W-1:0] o_sample;
  logic                o_valid;
  logic                i_ready;

  modport master (
    output o_sample,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_sample,
    input  o_valid,
    output i_ready
  );

endinterface

// File: rtl/sdadc_sync.sv
// rtl/sdadc_sync.sv - comparator bit synchroniser chain, reset to 1
//
// Purpose : captures the asynchronous comparator bit every clock through a
//           STAGES-deep flop chain.
// Ports   : i_clk, i_rst_n (async active-low), i_d async input bit,
//           o_first stage-1 Q (feedback DAC drive), o_last last-stage Q.
module sdadc_sync
  import sdadc_pkg::*;
#(
  parameter int STAGES = SDADC_SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_first,
  output logic o_last
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], i_d};
  end

  // Reset to all ones so the feedback DAC starts at its high level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign o_first = chain_q[0];
  assign o_last  = chain_q[STAGES-1];

endmodule

// File: rtl/sdadc_decim.sv
// rtl/sdadc_decim.sv - 1-bit sigma-delta capture with boxcar decimator
//
// Purpose : samples the comparator bit, drives the 1-bit feedback DAC and
//           counts ones over 2^DECIM_LOG2 enabled cycles, presenting each count
//           on a valid/ready interface with a sticky overrun flag.
// Ports   : i_clk, i_rst_n (async active-low), i_analog comparator bit,
//           i_enable conversion enable, i_ovr_clr clears o_overrun,
//           o_feedback feedback DAC drive, o_overrun sticky overwrite flag,
//           m_if sample interface (o_sample, o_valid, i_ready).
// Config  : SDADC_SIGNED_EN selects a two's complement sample around mid-scale.
module sdadc_decim
  import sdadc_pkg::*;
#(
  parameter int DECIM_LOG2  = SDADC_DECIM_LOG2_DEF,
  parameter int SYNC_STAGES = SDADC_SYNC_STAGES_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_analog,
  input  logic                 i_enable,
  input  logic                 i_ovr_clr,
  output logic                 o_feedback,
  output logic                 o_overrun,
  sdadc_decim_if.master        m_if
);

  localparam int SAMPLE_W = sdadc_sample_w(DECIM_LOG2);

  logic                  bit_b;

  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic [SAMPLE_W-1:0]   acc_q, acc_d;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  logic                  window_done;
  logic [SAMPLE_W-1:0]   count_w;
  logic [SAMPLE_W-1:0]   result_w;

  sdadc_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_analog),
    .o_first (o_feedback),
    .o_last  (bit_b)
  );

  // Count including the bit arriving this cycle; this is the window total
  // on the final cycle of the window.
  assign count_w     = acc_q + {{(SAMPLE_W-1){1'b0}}, bit_b};
  assign window_done = i_enable && (phase_q == '1);

`ifdef SDADC_SIGNED_EN
  localparam logic [SAMPLE_W-1:0] MID     = SAMPLE_W'(sdadc_mid_offset(DECIM_LOG2));
  localparam logic [SAMPLE_W-1:0] FULL    = SAMPLE_W'(1 << DECIM_LOG2);
  localparam logic [SAMPLE_W-1:0] POS_MAX = MID - 1'b1;

  // An all-ones window would be +MID, which does not fit; clamp it.
  assign result_w = (count_w == FULL) ? POS_MAX : (count_w - MID);
`else
  assign result_w = count_w;
`endif

  always_comb begin
    phase_d   = phase_q;
    acc_d     = acc_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    // Disabled or wrapping: the window restarts from zero.
    if (!i_enable || window_done) begin
      phase_d = '0;
      acc_d   = '0;
    end else begin
      phase_d = phase_q + {{(DECIM_LOG2-1){1'b0}}, 1'b1};
      acc_d   = count_w;
    end

    if (valid_q && m_if.i_ready) begin
      valid_d = 1'b0;
    end

    if (i_ovr_clr) begin
      overrun_d = 1'b0;
    end

    // A completing window overrides the transfer clear and the overrun clear.
    if (window_done) begin
      sample_d = result_w;
      valid_d  = 1'b1;
      if (valid_q && !m_if.i_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q   <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_if.o_sample = sample_q;
  assign m_if.o_valid  = valid_q;
  assign o_overrun     = overrun_q;

endmodule

// File: doc/sdadc_decim.md
Name: sdadc_decim

Overview:
- Parametrised successor to the single-flop 1-bit comparator capture.
- Samples the LVDS comparator bit and drives the 1-bit feedback DAC output (RC network).
- Boxcar-decimates the bitstream: counts ones over 2^DECIM_LOG2 cycles, producing a multi-bit sample with a valid/ready handshake.
- Sits between the comparator pad and the downstream DSP/mixer chain.

Parameters:
- DECIM_LOG2, 8, log2 of the decimation ratio; legal range 2..16.
- SYNC_STAGES, 2, synchroniser depth for the comparator bit; legal range 2..4.
- SAMPLE_W, DECIM_LOG2+1, derived localparam (not overridable); output sample width.

Ports:
- i_clk  in  1  system/sample clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_analog  in  1  comparator (LVDS) output, asynchronous to i_clk.
- i_enable  in  1  conversion enable.
- i_ready  in  1  downstream accepts sample.
- i_ovr_clr  in  1  clears sticky overrun.
- o_feedback  out  1  feedback DAC drive.
- o_sample  out  SAMPLE_W  decimated sample.
- o_valid  out  1  sample valid.
- o_overrun  out  1  sticky: unconsumed sample was overwritten.

Behaviour:
- Reset (async assert, sync release): sync chain = all 1, o_feedback = 1, accumulator = 0, phase counter = 0, o_sample = 0, o_valid = 0, o_overrun = 0.
- Sync chain: stage 1 captures i_analog every clock regardless of i_enable. o_feedback = stage-1 Q (one-cycle loop latency). The accumulator uses the last-stage output (bit b), so an input bit reaches the accumulator SYNC_STAGES cycles after capture.
- i_enable = 0: phase and accumulator are held at 0; o_sample, o_valid and o_overrun keep their values and the handshake still completes. Deasserting mid-window discards the partial window. Reasserting starts a full new window on the next edge.
- Window: each enabled cycle adds b to the accumulator and increments phase. When phase = 2^DECIM_LOG2-1:
  - on that edge, o_sample <= acc + b, acc <= 0, phase <= 0 (wrap), o_valid <= 1.
  - Result range is 0..2^DECIM_LOG2 inclusive, which fits SAMPLE_W bits.
- Handshake:
  - Transfer occurs on a cycle with o_valid & i_ready; o_valid then clears on the next edge unless a new sample completes on that same edge, in which case o_valid stays 1 with the new data.
  - Sample completes while o_valid & ~i_ready: o_sample is overwritten, o_valid stays 1, o_overrun <= 1.
  - o_sample is stable while o_valid is high and no new sample completes.
- o_overrun: sticky. Cleared by i_ovr_clr on the next edge; if an overrun event occurs on the same edge, set wins.
- Phase counter is DECIM_LOG2 bits wide, with natural wrap. Accumulator is SAMPLE_W bits wide and never overflows.
- Throughput: one sample per 2^DECIM_LOG2 enabled cycles; no backpressure onto the modulator.

Optional Feature:
- Macro: SDADC_SIGNED_EN.
- Defined: o_sample = two's complement of (count - 2^DECIM_LOG2/2), mid-scale = 0.
  - Range -2^(DECIM_LOG2-1)..+2^(DECIM_LOG2-1); +2^(DECIM_LOG2-1) saturates to 2^(DECIM_LOG2-1)-1.
  - Width stays SAMPLE_W.
- Undefined: o_sample = unsigned ones count.
- Timing is identical in both builds.

Decomposition:
- Package sdadc_pkg holds:
  - default DECIM_LOG2 and SYNC_STAGES constants;
  - function sdadc_sample_w(decim_log2), which returns decim_log2+1;
  - the signed mid-scale offset constant.
- One sub-module, sdadc_sync: parametrised SYNC_STAGES flop chain with reset value 1, exporting stage-1 Q (feedback) and last-stage Q.
- Decimator, handshake and overrun logic stay in sdadc_decim.

Test Plan (DECIM_LOG2=4, SYNC_STAGES=2):
- i_analog=1 constant, i_enable=1, i_ready=1 → first o_valid pulse 16 cycles after enable and one pulse per 16 cycles thereafter; after fill, o_sample=16 (signed build: 7). Check the first window only for chain-fill offset.
- i_analog=0 constant → o_sample=0 (signed build: -8 = 5'b11000); o_feedback=0 one cycle after i_analog falls.
- i_analog toggling 1,0 each cycle → o_sample=8 (signed build: 0); o_feedback follows i_analog delayed one cycle.
- i_ready=0 across two window completions → o_valid stays 1, o_sample holds the second window, o_overrun=1. Pulse i_ovr_clr → o_overrun=0 next edge. Overrun and i_ovr_clr on the same edge → o_overrun=1.
- i_analog=1, i_enable dropped after 5 enabled cycles, then raised → partial window discarded; next o_valid 16 enabled cycles after re-enable with o_sample=16.
- i_rst_n asserted mid-window with o_valid=1 → o_valid, o_sample, o_overrun go to 0 and o_feedback to 1 immediately (before next clock edge). After release, the first sample arrives after a full 16-cycle window.
